// File: rtl/fsk8_loopback_top.sv
// 8-FSK loopback: square-wave tone modulator feeding an edge-counting demodulator.
// One 3-bit symbol per SYM_CYCLES window, recovered on data_out one window later.
module fsk8_loopback_top #(
    parameter int SYM_CYCLES = 100,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] data_in,
    input  logic       start,
    output logic [2:0] data_out
);

    localparam logic [5:0] HALF [0:7] = '{6'd48, 6'd24, 6'd16, 6'd12, 6'd10, 6'd8, 6'd7, 6'd6};
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CYCLES - 1);
    localparam logic [4:0] EDGE_MAX = 5'd31;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] sym_cnt_reg, sym_cnt_next;
    logic [2:0]       tx_sym_reg, tx_sym_next;
    logic [5:0]       half_cnt_reg, half_cnt_next;
    logic             tone_reg, tone_next;
    logic             tone_d_reg, tone_d_next;
    logic [4:0]       edge_cnt_reg, edge_cnt_next;
    logic             valid_reg, valid_next;
    logic [2:0]       data_out_reg, data_out_next;

    logic [7:0]       half_hit_vec;
    logic             half_hit;
    logic             running;
    logic             tone_edge;

    // One comparator per tone so the selected half-period end is a simple mux.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_half
            assign half_hit_vec[gi] = (half_cnt_reg == HALF[gi] - 6'd1);
        end
    endgenerate

    assign half_hit  = half_hit_vec[tx_sym_reg];
    assign running   = (state_reg == ST_RUN);
    assign tone_edge = tone_reg ^ tone_d_reg;
    assign data_out  = data_out_reg;

    // Counts 2k+1 and 2k+2 both decode to k, so one missed edge is tolerated.
    function automatic logic [2:0] decode(input logic [4:0] c);
        logic [4:0] m;
        m = (c - 5'd1) >> 1;
        if (c == 5'd0)
            return 3'd0;
        else if (m > 5'd7)
            return 3'd7;
        else
            return m[2:0];
    endfunction

    always_comb begin
        state_next = state_reg;
        if (start)
            state_next = ST_RUN;
    end

    always_comb begin
        sym_cnt_next  = sym_cnt_reg;
        tx_sym_next   = tx_sym_reg;
        half_cnt_next = half_cnt_reg;
        tone_next     = tone_reg;
        tone_d_next   = tone_d_reg;
        edge_cnt_next = edge_cnt_reg;
        valid_next    = valid_reg;
        data_out_next = data_out_reg;

        if (running) begin
            sym_cnt_next = (sym_cnt_reg == SYM_LAST) ? '0 : sym_cnt_reg + 1'b1;

            if (sym_cnt_reg == '0) begin
                tx_sym_next   = data_in;
                half_cnt_next = 6'd0;
                tone_next     = 1'b0;
            end else if (half_hit) begin
                tone_next     = ~tone_reg;
                half_cnt_next = 6'd0;
            end else begin
                half_cnt_next = half_cnt_reg + 6'd1;
            end

            tone_d_next = tone_reg;

            // The edge seen here is the window-start clear of the previous
            // symbol's tone, so the new count starts from zero.
            if (sym_cnt_reg == CNT_W'(1)) begin
                if (valid_reg)
                    data_out_next = decode(edge_cnt_reg);
                edge_cnt_next = 5'd0;
                valid_next    = 1'b1;
            end else if (tone_edge && (edge_cnt_reg != EDGE_MAX)) begin
                edge_cnt_next = edge_cnt_reg + 5'd1;
            end
        end

        if (start) begin
            sym_cnt_next  = '0;
            edge_cnt_next = 5'd0;
            valid_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sym_cnt_reg  <= '0;
            tx_sym_reg   <= 3'd0;
            half_cnt_reg <= 6'd0;
            tone_reg     <= 1'b0;
            tone_d_reg   <= 1'b0;
            edge_cnt_reg <= 5'd0;
            valid_reg    <= 1'b0;
            data_out_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            sym_cnt_reg  <= sym_cnt_next;
            tx_sym_reg   <= tx_sym_next;
            half_cnt_reg <= half_cnt_next;
            tone_reg     <= tone_next;
            tone_d_reg   <= tone_d_next;
            edge_cnt_reg <= edge_cnt_next;
            valid_reg    <= valid_next;
            data_out_reg <= data_out_next;
        end
    end

endmodule

// File: tb/tb_fsk8_loopback_top.sv
// Scoreboard bench for fsk8_loopback_top: symbols queued at their latch edge,
// popped when data_out updates 101 edges later; tone toggles counted per window.
module tb_fsk8_loopback_top;

    logic       clk;
    logic       reset;
    logic [2:0] data_in;
    logic       start;
    logic [2:0] data_out;

    int         n_tests;
    int         n_fail;
    int         win_idx;
    logic [2:0] exp_q [$];
    logic [2:0] last_out;

    fsk8_loopback_top dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .start    (start),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Called at the negedge just after a latch edge; runs len cycles of the window.
    task automatic run_window(input logic [2:0] cur, input logic [2:0] nxt,
                              input bit first, input bit glitch, input int len);
        int         tog;
        logic       prev;
        logic [2:0] exp;
        tog  = 0;
        prev = dut.tone_reg;
        for (int p = 1; p <= len; p++) begin
            @(negedge clk);
            if (dut.tone_reg !== prev)
                tog++;
            prev = dut.tone_reg;
            if (p == 1) begin
                if (first) begin
                    check_val("first_hold", int'(data_out), int'(last_out));
                end else if (exp_q.size() == 0) begin
                    check_val("sb_empty", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check_val("dout", int'(data_out), int'(exp));
                    last_out = exp;
                end
            end
            if (p == 40 && glitch)
                data_in = cur ^ 3'b101;
            if (p == 99) begin
                check_val("hold99", int'(data_out), int'(last_out));
                data_in = nxt;
            end
        end
        if (len == 100) begin
            exp_q.push_back(nxt);
            check_val("toggles", tog, 2 * (int'(cur) + 1));
            $display("[TB] win %0d sym %0d out %0d toggles %0d", win_idx, cur, data_out, tog);
            win_idx++;
        end
    endtask

    // Called at a negedge; the window's first latch edge follows the start edge.
    task automatic do_start(input logic [2:0] sym0);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = sym0;
        exp_q.delete();
        @(negedge clk);
        exp_q.push_back(sym0);
    endtask

    initial begin
        logic [2:0] cur;
        logic [2:0] nxt;
        bit         resync;
        n_tests  = 0;
        n_fail   = 0;
        win_idx  = 0;
        last_out = 3'd0;
        reset    = 1'b1;
        start    = 1'b0;
        data_in  = 3'd0;

        repeat (20) @(negedge clk);
        check_val("rst_dout", int'(data_out), 0);
        check_val("rst_tone", int'(dut.tone_reg), 0);
        reset = 1'b0;
        @(negedge clk);

        cur    = 3'd0;
        resync = 1'b1;
        do_start(cur);
        for (int i = 0; i < 400; i++) begin
            nxt = 3'((i + 1) % 8);
            run_window(cur, nxt, resync, (i % 50) == 13, 100);
            cur    = nxt;
            resync = 1'b0;
            if (i == 203) begin
                run_window(cur, cur, 1'b0, 1'b0, 56);
                do_start(cur);
                resync = 1'b1;
            end
        end

        run_window(cur, 3'd5, 1'b0, 1'b0, 100);
        run_window(3'd5, 3'd3, 1'b0, 1'b0, 100);
        run_window(3'd3, 3'd3, 1'b0, 1'b0, 30);
        check_val("pre_rst", int'(data_out), 5);
        #2 reset = 1'b1;
        #1 check_val("async_rst", int'(data_out), 0);
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        last_out = 3'd0;
        data_in  = 3'd6;
        repeat (150) @(negedge clk);
        check_val("idle_dout", int'(data_out), 0);
        check_val("idle_tone", int'(dut.tone_reg), 0);

        do_start(3'd6);
        run_window(3'd6, 3'd2, 1'b1, 1'b0, 100);
        run_window(3'd2, 3'd4, 1'b0, 1'b0, 100);
        run_window(3'd4, 3'd7, 1'b0, 1'b1, 100);
        run_window(3'd7, 3'd1, 1'b0, 1'b0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
